// File: rtl/fpga_stream_arbiter_if.sv
// Port bundle for fpga_stream_arbiter: Avalon-MM CSR slave, two AXI4-Stream
// requesters (s0, s1) and the single AXI4-Stream sink port (m).
interface fpga_stream_arbiter_if #(
  parameter int DATA_W = 8
);
  logic [1:0]        avs_address;
  logic              avs_chipselect;
  logic              avs_write_n;
  logic [31:0]       avs_writedata;
  logic [31:0]       avs_readdata;
  logic [DATA_W-1:0] s0_tdata;
  logic              s0_tvalid;
  logic              s0_tlast;
  logic              s0_tready;
  logic [DATA_W-1:0] s1_tdata;
  logic              s1_tvalid;
  logic              s1_tlast;
  logic              s1_tready;
  logic [DATA_W-1:0] m_tdata;
  logic              m_tvalid;
  logic              m_tlast;
  logic              m_tready;

  modport slave (
    input  avs_address, avs_chipselect, avs_write_n, avs_writedata,
    output avs_readdata,
    input  s0_tdata, s0_tvalid, s0_tlast,
    output s0_tready,
    input  s1_tdata, s1_tvalid, s1_tlast,
    output s1_tready,
    output m_tdata, m_tvalid, m_tlast,
    input  m_tready
  );

  modport master (
    output avs_address, avs_chipselect, avs_write_n, avs_writedata,
    input  avs_readdata,
    output s0_tdata, s0_tvalid, s0_tlast,
    input  s0_tready,
    output s1_tdata, s1_tvalid, s1_tlast,
    input  s1_tready,
    input  m_tdata, m_tvalid, m_tlast,
    output m_tready
  );
endinterface

// File: rtl/fpga_stream_arbiter.sv
// Packet-granular two-requester AXI4-Stream arbiter feeding the FPGA data sink,
// with an Avalon-MM CSR for mode/enable control and per-port beat/packet counters.
module fpga_stream_arbiter #(
  parameter int DATA_W    = 8,
  parameter int MAX_BEATS = 4096,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  fpga_stream_arbiter_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    G0   = 2'd1,
    G1   = 2'd2
  } state_t;

  localparam int               BIP_W     = 14;
  localparam logic [BIP_W-1:0] LAST_BEAT = BIP_W'(MAX_BEATS - 1);
  localparam logic [BIP_W-1:0] BIP_ONE   = BIP_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t           state_r, state_next_s;
  logic             ctrl_en_r, ctrl_mode_r, last_served_r, owner_r, err_r;
  logic [BIP_W-1:0] beat_in_pkt_r;
  logic [CNT_W-1:0] beat0_r, beat1_r, pkt0_r, pkt1_r;
  logic             ctrl_wr_s, clr_s, at_max_s, xfer_s, src_last_s;
  logic             pkt_end_s, forced_s, grant_s, grant_port_s;
  logic             unused_wdata_s;

  assign ctrl_wr_s      = bus.avs_chipselect & ~bus.avs_write_n & (bus.avs_address == 2'd0);
  assign clr_s          = ctrl_wr_s & bus.avs_writedata[31];
  assign at_max_s       = (beat_in_pkt_r == LAST_BEAT);
  assign pkt_end_s      = xfer_s & (src_last_s | at_max_s);
  assign forced_s       = xfer_s & at_max_s & ~src_last_s;
  assign grant_s        = (state_r == IDLE) & (state_next_s != IDLE);
  assign unused_wdata_s = ^bus.avs_writedata[30:2];

  // Grant decision while idle; zero-latency routing from the owner while granted.
  always_comb begin
    state_next_s  = state_r;
    grant_port_s  = 1'b0;
    xfer_s        = 1'b0;
    src_last_s    = 1'b0;
    bus.m_tdata   = '0;
    bus.m_tvalid  = 1'b0;
    bus.m_tlast   = 1'b0;
    bus.s0_tready = 1'b0;
    bus.s1_tready = 1'b0;
    case (state_r)
      IDLE: begin
        if (ctrl_en_r && (bus.s0_tvalid || bus.s1_tvalid)) begin
          if (ctrl_mode_r || !(bus.s0_tvalid && bus.s1_tvalid)) begin
            grant_port_s = ~bus.s0_tvalid;
          end else begin
            grant_port_s = ~last_served_r;
          end
          state_next_s = grant_port_s ? G1 : G0;
        end else begin
          state_next_s = IDLE;
        end
      end
      G0: begin
        bus.m_tdata   = bus.s0_tdata;
        bus.m_tvalid  = bus.s0_tvalid;
        bus.m_tlast   = bus.s0_tlast | at_max_s;
        bus.s0_tready = bus.m_tready;
        xfer_s        = bus.s0_tvalid & bus.m_tready;
        src_last_s    = bus.s0_tlast;
        state_next_s  = (xfer_s && (bus.s0_tlast || at_max_s)) ? IDLE : G0;
      end
      G1: begin
        bus.m_tdata   = bus.s1_tdata;
        bus.m_tvalid  = bus.s1_tvalid;
        bus.m_tlast   = bus.s1_tlast | at_max_s;
        bus.s1_tready = bus.m_tready;
        xfer_s        = bus.s1_tvalid & bus.m_tready;
        src_last_s    = bus.s1_tlast;
        state_next_s  = (xfer_s && (bus.s1_tlast || at_max_s)) ? IDLE : G1;
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // FSM state, grant owner, round-robin history and position within the packet.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r       <= IDLE;
      last_served_r <= 1'b1;
      owner_r       <= 1'b0;
      beat_in_pkt_r <= '0;
    end else begin
      state_r <= state_next_s;
      if (grant_s) begin
        owner_r <= grant_port_s;
      end
      if (pkt_end_s) begin
        last_served_r <= owner_r;
        beat_in_pkt_r <= '0;
      end else if (xfer_s) begin
        beat_in_pkt_r <= beat_in_pkt_r + BIP_ONE;
      end
    end
  end

  // CTRL register and sticky forced-end flag; CLR itself is never stored.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_en_r   <= 1'b0;
      ctrl_mode_r <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      if (ctrl_wr_s) begin
        ctrl_en_r   <= bus.avs_writedata[0];
        ctrl_mode_r <= bus.avs_writedata[1];
      end
      if (clr_s) begin
        err_r <= 1'b0;
      end else if (forced_s) begin
        err_r <= 1'b1;
      end
    end
  end

  // Per-port beat and packet counters; a clear overrides a coincident increment.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      beat0_r <= '0;
      beat1_r <= '0;
      pkt0_r  <= '0;
      pkt1_r  <= '0;
    end else if (clr_s) begin
      beat0_r <= '0;
      beat1_r <= '0;
      pkt0_r  <= '0;
      pkt1_r  <= '0;
    end else begin
      if (xfer_s && !owner_r) beat0_r <= beat0_r + CNT_ONE;
      if (xfer_s && owner_r)  beat1_r <= beat1_r + CNT_ONE;
      if (pkt_end_s && !owner_r) pkt0_r <= pkt0_r + CNT_ONE;
      if (pkt_end_s && owner_r)  pkt1_r <= pkt1_r + CNT_ONE;
    end
  end

  // Zero-wait-state CSR read decode.
  always_comb begin
    bus.avs_readdata = '0;
    case (bus.avs_address)
      2'd0:    bus.avs_readdata = {30'd0, ctrl_mode_r, ctrl_en_r};
      2'd1:    bus.avs_readdata = {2'd0, beat_in_pkt_r, 13'd0, err_r, owner_r, (state_r != IDLE)};
      2'd2:    bus.avs_readdata = {pkt0_r, beat0_r};
      2'd3:    bus.avs_readdata = {pkt1_r, beat1_r};
      default: bus.avs_readdata = '0;
    endcase
  end
endmodule

// File: tb/tb_fpga_stream_arbiter.sv
// Self-checking bench for fpga_stream_arbiter: stream sources driven from packet
// queues, output checked against a packet-level arbitration model.
module tb_fpga_stream_arbiter;
  localparam int DATA_W    = 8;
  localparam int MAX_BEATS = 8;
  localparam int CNT_W     = 16;

  logic clk;
  logic reset_n;
  int   errors = 0;
  int   checks = 0;

  logic [7:0] sd0[$];
  logic [7:0] sd1[$];
  bit         sl0[$];
  bit         sl1[$];
  int         i0, i1;
  logic [7:0] ed[$];
  bit         el[$];
  bit         es[$];
  int         exp_beats0, exp_beats1, exp_pkts0, exp_pkts1;
  bit         exp_err;

  fpga_stream_arbiter_if #(.DATA_W(DATA_W)) bus ();

  fpga_stream_arbiter #(
    .DATA_W(DATA_W), .MAX_BEATS(MAX_BEATS), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive_src();
    if (i0 < sd0.size()) begin
      bus.s0_tvalid = 1'b1; bus.s0_tdata = sd0[i0]; bus.s0_tlast = sl0[i0];
    end else begin
      bus.s0_tvalid = 1'b0; bus.s0_tdata = 8'h00; bus.s0_tlast = 1'b0;
    end
    if (i1 < sd1.size()) begin
      bus.s1_tvalid = 1'b1; bus.s1_tdata = sd1[i1]; bus.s1_tlast = sl1[i1];
    end else begin
      bus.s1_tvalid = 1'b0; bus.s1_tdata = 8'h00; bus.s1_tlast = 1'b0;
    end
  endtask

  task automatic add_pkt(input bit src, input int len, input int base);
    for (int k = 0; k < len; k++) begin
      logic [7:0] d;
      d = (base < 0) ? 8'($urandom_range(255)) : 8'(base + k);
      if (src) begin sd1.push_back(d); sl1.push_back(k == len - 1); end
      else     begin sd0.push_back(d); sl0.push_back(k == len - 1); end
    end
  endtask

  task automatic csr_write(input logic [1:0] a, input logic [31:0] d);
    bus.avs_address = a; bus.avs_writedata = d;
    bus.avs_chipselect = 1'b1; bus.avs_write_n = 1'b0;
    @(posedge clk); #1;
    bus.avs_chipselect = 1'b0; bus.avs_write_n = 1'b1;
  endtask

  task automatic csr_read(input logic [1:0] a, output logic [31:0] d);
    bus.avs_address = a;
    #1 d = bus.avs_readdata;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    bus.avs_address = 2'd0; bus.avs_chipselect = 1'b0;
    bus.avs_write_n = 1'b1; bus.avs_writedata = 32'd0;
    sd0.delete(); sd1.delete(); sl0.delete(); sl1.delete();
    ed.delete(); el.delete(); es.delete();
    i0 = 0; i1 = 0;
    drive_src();
    bus.m_tready = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // Packet-level model: split source packets into chunks of at most MAX_BEATS,
  // then order chunks by the arbitration rule (sources are always valid while non-empty).
  task automatic build_expected(input bit fixed);
    int cs0[$]; int cl0[$]; int cs1[$]; int cl1[$];
    int p0 = 0; int p1 = 0; bit turn = 1'b0;
    exp_err = 1'b0;
    for (int s = 0; s < 2; s++) begin
      int n   = s ? sd1.size() : sd0.size();
      int len = 0;
      for (int k = 0; k < n; k++) begin
        bit l = s ? sl1[k] : sl0[k];
        len++;
        if (l || len == MAX_BEATS) begin
          if (s == 1) begin cs1.push_back(k - len + 1); cl1.push_back(len); end
          else        begin cs0.push_back(k - len + 1); cl0.push_back(len); end
          if (!l) exp_err = 1'b1;
          len = 0;
        end
      end
    end
    exp_beats0 = sd0.size(); exp_beats1 = sd1.size();
    exp_pkts0  = cs0.size(); exp_pkts1  = cs1.size();
    while (p0 < cs0.size() || p1 < cs1.size()) begin
      bit pick;
      int st, ln;
      if (p0 < cs0.size() && p1 < cs1.size()) pick = fixed ? 1'b0 : turn;
      else pick = (p0 < cs0.size()) ? 1'b0 : 1'b1;
      if (pick) begin st = cs1[p1]; ln = cl1[p1]; p1++; end
      else      begin st = cs0[p0]; ln = cl0[p0]; p0++; end
      for (int j = 0; j < ln; j++) begin
        if (pick) ed.push_back(sd1[st + j]);
        else      ed.push_back(sd0[st + j]);
        el.push_back(j == ln - 1);
        es.push_back(pick);
      end
      turn = ~pick;
    end
  endtask

  // pct < 0 toggles m_tready every cycle; en_off_at > 0 clears EN after that many beats.
  task automatic run_stream(input int pct, input int limit, input int en_off_at);
    int got = 0; int cyc = 0;
    bit prev_end = 1'b0; bit held = 1'b0; bit en_done = 1'b0;
    logic [7:0] held_d = 8'h00;
    bit f0, f1, src;
    if (limit == 0) limit = ed.size();
    drive_src();
    bus.m_tready = (pct < 0) ? 1'b1 : (int'($urandom_range(99)) < pct);
    while (got < limit && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (prev_end) begin
        checks++;
        if ({bus.m_tvalid, bus.s0_tready, bus.s1_tready} !== 3'b000) begin
          errors++;
          $display("FAIL bubble: valid/rdy0/rdy1=%b expected 000 after beat %0d",
                   {bus.m_tvalid, bus.s0_tready, bus.s1_tready}, got);
        end
      end
      if (held) begin
        checks++;
        if (bus.m_tvalid !== 1'b1 || bus.m_tdata !== held_d) begin
          errors++;
          $display("FAIL stall_hold: valid=%b data=%h expected valid=1 data=%h",
                   bus.m_tvalid, bus.m_tdata, held_d);
        end
      end
      if (bus.m_tvalid === 1'b1 && got < limit) begin
        src = es[got];
        checks++;
        if ((src ? bus.s1_tready : bus.s0_tready) !== bus.m_tready ||
            (src ? bus.s0_tready : bus.s1_tready) !== 1'b0) begin
          errors++;
          $display("FAIL owner_ready: rdy0=%b rdy1=%b expected owner s%0d ready=%b, other 0",
                   bus.s0_tready, bus.s1_tready, src, bus.m_tready);
        end
      end
      f0 = bus.s0_tvalid & bus.s0_tready;
      f1 = bus.s1_tvalid & bus.s1_tready;
      held = bus.m_tvalid & ~bus.m_tready;
      held_d = bus.m_tdata;
      prev_end = 1'b0;
      if (bus.m_tvalid && bus.m_tready) begin
        checks++;
        if (bus.m_tdata !== ed[got] || bus.m_tlast !== el[got] || (es[got] ? f1 : f0) !== 1'b1) begin
          errors++;
          $display("FAIL beat %0d: data=%h last=%b src_fire=%b expected data=%h last=%b from s%0d",
                   got, bus.m_tdata, bus.m_tlast, es[got] ? f1 : f0, ed[got], el[got], es[got]);
        end
        prev_end = el[got];
        got++;
      end
      @(posedge clk); #1;
      if (f0) i0++;
      if (f1) i1++;
      drive_src();
      bus.avs_chipselect = 1'b0; bus.avs_write_n = 1'b1;
      if (en_off_at > 0 && got == en_off_at && !en_done) begin
        bus.avs_address = 2'd0; bus.avs_writedata = 32'd0;
        bus.avs_chipselect = 1'b1; bus.avs_write_n = 1'b0;
        en_done = 1'b1;
      end
      if (pct < 0) bus.m_tready = ~bus.m_tready;
      else         bus.m_tready = (int'($urandom_range(99)) < pct);
    end
    bus.avs_chipselect = 1'b0; bus.avs_write_n = 1'b1;
    checks++;
    if (got != limit) begin
      errors++;
      $display("FAIL stream_timeout: got %0d beats expected %0d", got, limit);
    end
  endtask

  task automatic check_counters();
    logic [31:0] d;
    csr_read(2'd2, d);
    checks++;
    if (d !== {exp_pkts0[15:0], exp_beats0[15:0]}) begin
      errors++; $display("FAIL cnt0: got %h expected %h", d, {exp_pkts0[15:0], exp_beats0[15:0]});
    end
    csr_read(2'd3, d);
    checks++;
    if (d !== {exp_pkts1[15:0], exp_beats1[15:0]}) begin
      errors++; $display("FAIL cnt1: got %h expected %h", d, {exp_pkts1[15:0], exp_beats1[15:0]});
    end
    csr_read(2'd1, d);
    checks++;
    if (d[2] !== exp_err || d[0] !== 1'b0) begin
      errors++; $display("FAIL stat: err=%b busy=%b expected err=%b busy=0", d[2], d[0], exp_err);
    end
  endtask

  task automatic test_reset();
    logic [31:0] d;
    do_reset();
    checks++;
    if ({bus.m_tvalid, bus.m_tlast, bus.s0_tready, bus.s1_tready} !== 4'b0000 || bus.m_tdata !== 8'h00) begin
      errors++; $display("FAIL reset_outputs: got %b/%h expected 0000/00",
                         {bus.m_tvalid, bus.m_tlast, bus.s0_tready, bus.s1_tready}, bus.m_tdata);
    end
    for (int a = 0; a < 4; a++) begin
      csr_read(2'(a), d);
      checks++;
      if (d !== 32'h0000_0000) begin
        errors++; $display("FAIL reset_csr%0d: got %h expected 00000000", a, d);
      end
    end
  endtask

  task automatic test_round_robin();
    logic [31:0] d;
    do_reset();
    csr_write(2'd0, 32'h0000_0001);
    add_pkt(1'b0, 3, 'h10); add_pkt(1'b0, 3, 'h10);
    add_pkt(1'b1, 3, 'h20); add_pkt(1'b1, 3, 'h20);
    build_expected(1'b0);
    run_stream(100, 0, 0);
    check_counters();
    csr_read(2'd2, d);
    checks++;
    if (d !== 32'h0002_0006) begin
      errors++; $display("FAIL rr_cnt0: got %h expected 00020006", d);
    end
  endtask

  task automatic test_fixed_priority();
    do_reset();
    csr_write(2'd0, 32'h0000_0003);
    for (int k = 0; k < 3; k++) add_pkt(1'b0, 2, -1);
    for (int k = 0; k < 2; k++) add_pkt(1'b1, 2, -1);
    build_expected(1'b1);
    run_stream(100, 0, 0);
    check_counters();
  endtask

  task automatic test_stall();
    do_reset();
    csr_write(2'd0, 32'h0000_0001);
    add_pkt(1'b1, 4, 'h40);
    build_expected(1'b0);
    run_stream(-1, 0, 0);
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (bus.m_tvalid !== 1'b0) begin
        errors++; $display("FAIL stall_extra: m_tvalid=%b expected 0", bus.m_tvalid);
      end
    end
    @(posedge clk); #1;
    check_counters();
  endtask

  task automatic test_forced_end();
    logic [31:0] d;
    do_reset();
    csr_write(2'd0, 32'h0000_0001);
    add_pkt(1'b0, 10, 'h30);
    build_expected(1'b0);
    run_stream(100, 0, 0);
    check_counters();
    csr_write(2'd0, 32'h8000_0001);
    csr_read(2'd2, d);
    checks++;
    if (d !== 32'h0000_0000) begin
      errors++; $display("FAIL clr_cnt0: got %h expected 00000000", d);
    end
    csr_read(2'd1, d);
    checks++;
    if (d[2] !== 1'b0) begin
      errors++; $display("FAIL clr_err: got %b expected 0", d[2]);
    end
    csr_read(2'd0, d);
    checks++;
    if (d !== 32'h0000_0001) begin
      errors++; $display("FAIL clr_ctrl: got %h expected 00000001", d);
    end
  endtask

  task automatic test_en_clear();
    logic [31:0] d;
    do_reset();
    csr_write(2'd0, 32'h0000_0001);
    add_pkt(1'b0, 5, 'h50);
    add_pkt(1'b0, 3, 'h60);
    build_expected(1'b0);
    run_stream(100, 5, 2);
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (bus.m_tvalid !== 1'b0 || bus.s0_tready !== 1'b0) begin
      errors++; $display("FAIL en_idle: valid=%b rdy0=%b expected 0/0", bus.m_tvalid, bus.s0_tready);
    end
    csr_read(2'd1, d);
    checks++;
    if (d[0] !== 1'b0) begin
      errors++; $display("FAIL en_busy: got %b expected 0", d[0]);
    end
    csr_read(2'd2, d);
    checks++;
    if (d !== 32'h0001_0005) begin
      errors++; $display("FAIL en_cnt0: got %h expected 00010005", d);
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 4; r++) begin
      bit mode;
      do_reset();
      mode = 1'($urandom_range(1));
      csr_write(2'd0, {30'd0, mode, 1'b1});
      for (int k = 0; k < 4; k++) begin
        add_pkt(1'b0, int'($urandom_range(12, 1)), -1);
        add_pkt(1'b1, int'($urandom_range(12, 1)), -1);
      end
      build_expected(mode);
      run_stream(60, 0, 0);
      check_counters();
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    int fired = 0; int cyc = 0; bit f0;
    do_reset();
    csr_write(2'd0, 32'h0000_0001);
    add_pkt(1'b0, 6, 'h70);
    drive_src();
    bus.m_tready = 1'b1;
    while (fired < 2 && cyc < 50) begin
      @(negedge clk);
      cyc++;
      f0 = bus.s0_tvalid & bus.s0_tready;
      if (f0) fired++;
      @(posedge clk); #1;
      if (f0) i0++;
      drive_src();
    end
    checks++;
    if (fired != 2) begin
      errors++; $display("FAIL rst_mid_timeout: got %0d beats expected 2", fired);
    end
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({bus.m_tvalid, bus.s0_tready, bus.s1_tready} !== 3'b000) begin
      errors++; $display("FAIL rst_mid_outputs: got %b expected 000",
                         {bus.m_tvalid, bus.s0_tready, bus.s1_tready});
    end
    repeat (2) @(posedge clk);
    #1;
    sd0.delete(); sl0.delete(); i0 = 0;
    drive_src();
    reset_n = 1'b1;
    @(posedge clk); #1;
    for (int a = 0; a < 3; a++) begin
      csr_read(2'(a), d);
      checks++;
      if (d !== 32'h0000_0000) begin
        errors++; $display("FAIL rst_mid_csr%0d: got %h expected 00000000", a, d);
      end
    end
  endtask

  initial begin
    reset_n = 1'b0;
    test_reset();
    test_round_robin();
    test_fixed_priority();
    test_stall();
    test_forced_end();
    test_en_clear();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fpga_stream_arbiter.md
Name: fpga_stream_arbiter

Overview:
- Shares the single 8-bit AXI4-Stream sink port of the FPGA data sink between two stream requesters (s0, s1), e.g. a test-pattern generator and an ADC capture path.
- Arbitrates at packet granularity: a grant holds until tlast, or until a forced end at MAX_BEATS.
- An Avalon-MM slave CSR selects round-robin or fixed-priority mode, gates arbitration on/off, and exposes per-port beat and packet counters to the HPS.

Parameters:
- DATA_W, 8, stream data width.
- MAX_BEATS, 4096, maximum beats per granted packet; matches the sink RAM depth.
- CNT_W, 16, width of each beat and packet counter.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- avs_address  in  2  CSR word select.
- avs_chipselect  in  1  CSR select.
- avs_write_n  in  1  active-low write strobe.
- avs_writedata  in  32  CSR write data.
- avs_readdata  out  32  CSR read data; combinational decode, zero wait states.
- s0_tdata  in  DATA_W  requester 0 data.
- s0_tvalid  in  1  requester 0 valid.
- s0_tlast  in  1  requester 0 end of packet.
- s0_tready  out  1  requester 0 ready.
- s1_tdata, s1_tvalid, s1_tlast, s1_tready: same as s0, for requester 1.
- m_tdata  out  DATA_W  to sink axis4_s_tdata.
- m_tvalid  out  1  to sink axis4_s_tvalid.
- m_tlast  out  1  to sink axis4_s_tlast.
- m_tready  in  1  from sink axis4_s_tready.

Behaviour:
- Clock and reset: one clock, clk. reset_n is asynchronous and active-low.
- Reset state:
  - FSM in IDLE; last_served = 1, so port 0 wins first; CTRL = 0; all counters 0; ERR = 0.
  - All tready and m_* outputs are 0.
  - A reset mid-packet drops the packet. No output glitch is permitted beyond the reset assertion edge.
- CSR map:
  - Address 0 CTRL (rw):
    - bit0 EN: arbitration enable.
    - bit1 MODE: 0 = round-robin, 1 = fixed priority with port 0 highest.
    - bit31 CLR: write-1 clears all counters and ERR in the same cycle. CLR is not stored and reads back 0.
  - Address 1 STAT (ro):
    - bit0 BUSY: FSM not in IDLE.
    - bit1 OWNER: current or last grant.
    - bit2 ERR: sticky forced-end flag.
    - bits[29:16] beat_in_pkt.
  - Address 2 CNT0 (ro): {pkt0[15:0], beat0[15:0]}.
  - Address 3 CNT1 (ro): {pkt1, beat1}.
- FSM states: IDLE, G0, G1.
  - IDLE: all tready = 0 and m_tvalid = 0.
  - IDLE -> grant: if EN and at least one s*_tvalid, grant on the next edge.
    - MODE=1: s0 wins if valid.
    - MODE=0: if both are valid, the port != last_served wins; otherwise the single valid port wins.
  - G0 / G1 routing is combinational, zero latency:
    - m_tdata / m_tvalid / m_tlast come from the owner.
    - owner tready = m_tready; the other port's tready = 0.
  - Transfer: a beat transfers when m_tvalid & m_tready. Each transfer increments beat_in_pkt and the owner's beat counter.
  - Grant -> IDLE: on a transferred beat with tlast, or with beat_in_pkt == MAX_BEATS-1.
    - On exit: last_served = owner; owner's packet counter increments; beat_in_pkt = 0.
    - Each packet therefore costs exactly one idle bubble cycle.
  - Forced end: on the MAX_BEATS-th beat without s tlast, m_tlast is forced to 1 and ERR is set.
    - The remainder of that source packet is treated as a new packet at the next grant.
- EN cleared mid-packet: the current packet completes normally; no new grant is issued after it.
- Counters wrap modulo 2^CNT_W.
- CLR coincident with a counter increment: the clear wins, and the counter reads 0.
- CSR write to CTRL coincident with a grant decision: the decision uses the pre-write CTRL value.

Test Plan:
- Reset, then EN=1, MODE=0, s0 and s1 each assert a 3-beat packet continuously (s0 0x10..0x12, s1 0x20..0x22), m_tready=1 -> m_tdata sequence 10,11,12,20,21,22,10,... with one bubble between packets; CNT0 = 0x0001_0003 after the first packet.
- MODE=1, both ports always valid with 2-beat packets -> only s0 is ever granted; s1_tready stays 0; CNT1 = 0.
- m_tready toggled 1/0 every cycle during a 4-beat s1 packet -> exactly 4 transfers; data is held stable while stalled; the owner's tready mirrors m_tready.
- MAX_BEATS=8 build, s0 sends 10 beats with tlast on beat 10 -> beat 8 appears with m_tlast=1; STAT.ERR=1; beats 9-10 are delivered as a second 2-beat packet; pkt0 = 2.
- EN cleared on beat 2 of a 5-beat packet -> all 5 beats delivered, then FSM stays IDLE (BUSY=0) despite pending tvalid.
- reset_n asserted mid-packet at beat 3 -> all tready and m_tvalid are 0 immediately; CTRL and counters read 0 after release.
